if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/if_stage_if.sv | 37 +++
 rtl/pc_reg.sv | 34 +++
 rtl/if_stage.sv | 121 ++++++++++++
 tb/tb_if_stage.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 fetch definitions: data width, canonical NOP, default reset vector
// and the fetch FSM state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,  // request pending on the memory port
        FETCH_WAIT = 2'd1,  // one request outstanding
        FETCH_HOLD = 2'd2   // instruction buffered for decode
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's memory, redirect and decode-side signals.
// master = fetch stage, slave = its environment (memory, execute, decode).
interface if_stage_if;
    import riscv_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            id_ready;
    logic            id_valid;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc_plus4;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        input  id_ready,
        output id_valid, id_instr, id_pc, id_pc_plus4
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        output id_ready,
        input  id_valid, id_instr, id_pc, id_pc_plus4
    );

endinterface

// File: rtl/pc_reg.sv
// Fetch program counter: async reset to the reset vector, word-aligned load
// (redirect has priority) and +4 increment with natural 32-bit wrap.
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic            inc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    logic [XLEN-1:0] pc_q;

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= word_align(load_pc);
        end else if (inc) begin
            pc_q <= pc_q + XLEN'(4);
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + XLEN'(4);

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding request FSM (REQ/WAIT/HOLD) that
// feeds a registered one-entry buffer to decode and honours execute redirects.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    if_stage_if.master bus
);

    fetch_state_t    state, state_d;
    logic            kill_q, kill_d;

    logic            req_active;
    logic            pc_load;
    logic            pc_inc;
    logic            capture;
    logic            buf_drop;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;

    logic            id_valid_q;
    logic [XLEN-1:0] id_instr_q;
    logic [XLEN-1:0] id_pc_q;
    logic [XLEN-1:0] id_pc_plus4_q;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_pc  (bus.redirect_pc),
        .inc      (pc_inc),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH_REQ;
            kill_q <= 1'b0;
        end else begin
            state  <= state_d;
            kill_q <= kill_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state;
        kill_d  = kill_q;
        case (state)
            FETCH_REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = FETCH_WAIT;
                    kill_d  = bus.redirect_valid;
                end
            end
            FETCH_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    // A killed or concurrently redirected response is dropped.
                    state_d = (kill_q || bus.redirect_valid) ? FETCH_REQ : FETCH_HOLD;
                    kill_d  = 1'b0;
                end else if (bus.redirect_valid) begin
                    kill_d  = 1'b1;
                end
            end
            FETCH_HOLD: begin
                if (bus.redirect_valid || bus.id_ready) begin
                    state_d = FETCH_REQ;
                end
            end
            default: begin
                state_d = FETCH_REQ;
                kill_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        req_active = (state == FETCH_REQ);
        pc_load    = bus.redirect_valid;
        pc_inc     = (state == FETCH_HOLD) && bus.id_ready && !bus.redirect_valid;
        capture    = (state == FETCH_WAIT) && bus.imem_rsp_valid
                     && !kill_q && !bus.redirect_valid;
        buf_drop   = (state == FETCH_HOLD) && (bus.id_ready || bus.redirect_valid);
    end

    // NOTE: the decode buffer is reset explicitly because its reset contents
    // (NOP, pc 0) are architecturally visible on id_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
        end else if (capture) begin
            id_valid_q    <= 1'b1;
            id_instr_q    <= bus.imem_rsp_data;
            id_pc_q       <= pc;
            id_pc_plus4_q <= pc_plus4;
        end else if (buf_drop) begin
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
        end
    end

    // Reset gating keeps the request quiet while rst_n is low yet lets it
    // appear in the very first cycle after release.
    assign bus.imem_req_valid = req_active && rst_n;
    assign bus.imem_req_addr  = pc;

    assign bus.id_valid       = id_valid_q;
    assign bus.id_instr       = id_instr_q;
    assign bus.id_pc          = id_pc_q;
    assign bus.id_pc_plus4    = id_pc_plus4_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// scored against a program-order model of the fetch stream.
module tb_if_stage;
    import riscv_pkg::*;

    localparam logic [31:0] RST_A = 32'h0000_0000;
    localparam logic [31:0] RST_B = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_stage_if bus ();
    if_stage_if bus2 ();

    if_stage #(.RESET_PC(RST_A)) dut      (.clk(clk), .rst_n(rst_n), .bus(bus));
    if_stage #(.RESET_PC(RST_B)) dut_wrap (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int checks = 0;
    int errors = 0;

    // stimulus knobs
    logic        drv_ready, drv_id_ready, drv_redir;
    logic [31:0] drv_target;
    int          lat;

    // model state
    bit          pend_valid;
    logic [31:0] pend_addr;
    int          pend_due;
    int          cyc;
    logic [31:0] exp_pc;
    logic [31:0] acc_q[$];
    logic [31:0] hs_q[$];
    bit          stall_prev;
    logic [31:0] stall_pc, stall_instr;

    // sampled outputs
    logic        s_rv, s_iv;
    logic [31:0] s_ra, s_instr, s_pc, s_p4;

    int          hs_before;
    logic [31:0] hp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic zero_inputs();
        bus.imem_req_ready  = 1'b0;  bus2.imem_req_ready  = 1'b0;
        bus.imem_rsp_valid  = 1'b0;  bus2.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = '0;    bus2.imem_rsp_data   = '0;
        bus.redirect_valid  = 1'b0;  bus2.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;    bus2.redirect_pc     = '0;
        bus.id_ready        = 1'b0;  bus2.id_ready        = 1'b0;
    endtask

    // One clock: sample at negedge, score, drive the memory/decode/redirect side.
    task automatic cycle();
        @(negedge clk);
        s_rv = bus.imem_req_valid;  s_ra = bus.imem_req_addr;
        s_iv = bus.id_valid;        s_instr = bus.id_instr;
        s_pc = bus.id_pc;           s_p4 = bus.id_pc_plus4;

        if (!s_iv) check("nop_when_idle", s_instr, NOP_INSTR);
        if (stall_prev) begin
            check("hold_valid", {31'b0, s_iv}, 32'd1);
            check("hold_pc", s_pc, stall_pc);
            check("hold_instr", s_instr, stall_instr);
        end

        bus.imem_req_ready = drv_ready;
        bus.id_ready       = drv_id_ready;
        bus.redirect_valid = drv_redir;
        bus.redirect_pc    = drv_target;
        if (pend_valid && pend_due == cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_fn(pend_addr);
            pend_valid = 1'b0;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end

        if (s_rv && drv_ready) begin
            check("one_outstanding", {31'b0, pend_valid}, 32'd0);
            check("addr_aligned", {30'b0, s_ra[1:0]}, 32'd0);
            pend_valid = 1'b1;
            pend_addr  = s_ra;
            pend_due   = cyc + lat;
            acc_q.push_back(s_ra);
        end

        if (s_iv && drv_id_ready) begin
            check("hs_pc", s_pc, exp_pc);
            check("hs_instr", s_instr, mem_fn(exp_pc));
            check("hs_pc_plus4", s_p4, exp_pc + 32'd4);
            hs_q.push_back(s_pc);
            exp_pc = exp_pc + 32'd4;
        end
        if (drv_redir) exp_pc = drv_target & ~32'h3;

        stall_prev  = s_iv && !drv_id_ready && !drv_redir;
        stall_pc    = s_pc;
        stall_instr = s_instr;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        zero_inputs();
        #1;
        check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
        check("rst_id_instr", bus.id_instr, NOP_INSTR);
        check("rst_id_pc", bus.id_pc, 32'd0);
        check("rst_id_pc_plus4", bus.id_pc_plus4, 32'd0);
        pend_valid = 1'b0;
        stall_prev = 1'b0;
        exp_pc     = RST_A;
        acc_q.delete();
        hs_q.delete();
        drv_ready = 1'b1; drv_id_ready = 1'b1; drv_redir = 1'b0; drv_target = '0; lat = 1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_id_valid(input string tag);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!s_iv && n < 20);
        check(tag, {31'b0, s_iv}, 32'd1);
    endtask

    task automatic wait_accepts(input string tag, input int count);
        int n = 0;
        while (acc_q.size() < count && n < 40) begin
            cycle();
            n++;
        end
        check(tag, 32'(acc_q.size()), 32'(count));
    endtask

    initial begin
        zero_inputs();
        cyc = 0;
        do_reset();

        // straight-line fetch with single-cycle memory
        cycle();
        check("first_req_valid", {31'b0, s_rv}, 32'd1);
        check("first_req_addr", s_ra, RST_A);
        repeat (8) cycle();
        check("accepts_in_9", 32'(acc_q.size()), 32'd3);
        check("transfers_in_9", 32'(hs_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (acc_q.size() > i) check("seq_req_addr", acc_q[i], 32'(4 * i));
            if (hs_q.size() > i)  check("seq_id_pc", hs_q[i], 32'(4 * i));
        end

        // decode stall in HOLD
        drv_id_ready = 1'b0;
        wait_id_valid("stall_reach_hold");
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_no_req", {31'b0, s_rv}, 32'd0);
        end
        hp = s_pc;
        drv_id_ready = 1'b1;
        cycle();
        drv_id_ready = 1'b0;
        cycle();
        check("resume_req_valid", {31'b0, s_rv}, 32'd1);
        check("resume_req_addr", s_ra, hp + 32'd4);

        // redirect while waiting on 0x8
        do_reset();
        lat = 3;
        wait_accepts("reach_req_8", 3);
        if (acc_q.size() == 3) check("wait_on_addr", acc_q[2], 32'h8);
        hs_before = hs_q.size();
        drv_redir = 1'b1; drv_target = 32'h100;
        cycle();
        drv_redir = 1'b0;
        wait_accepts("reach_redir_req", 4);
        if (acc_q.size() == 4) check("redir_req_addr", acc_q[3], 32'h100);
        check("killed_not_delivered", 32'(hs_q.size()), 32'(hs_before));

        // redirect coinciding with decode handshake
        drv_id_ready = 1'b0;
        wait_id_valid("hold_before_redir");
        check("hold_pc_is_target", s_pc, 32'h100);
        hs_before = hs_q.size();
        drv_id_ready = 1'b1; drv_redir = 1'b1; drv_target = 32'h203;
        cycle();
        drv_id_ready = 1'b0; drv_redir = 1'b0;
        check("redir_hs_counted", 32'(hs_q.size()), 32'(hs_before + 1));
        cycle();
        check("redir_id_valid_low", {31'b0, s_iv}, 32'd0);
        check("redir_req_valid", {31'b0, s_rv}, 32'd1);
        check("redir_req_aligned", s_ra, 32'h200);
        wait_id_valid("redir_refill");
        check("redir_refill_pc", s_pc, 32'h200);

        // reset while holding an instruction
        do_reset();
        cycle();
        check("restart_req_valid", {31'b0, s_rv}, 32'd1);
        check("restart_req_addr", s_ra, RST_A);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drv_ready    = ($urandom_range(0, 3) != 0);
            drv_id_ready = ($urandom_range(0, 2) != 0);
            drv_redir    = ($urandom_range(0, 9) == 0);
            drv_target   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : 32'($urandom_range(0, 4095));
            lat          = $urandom_range(1, 3);
            cycle();
        end
        check("rand_progress", {31'b0, hs_q.size() >= 100}, 32'd1);

        // wrap-around from the top of the address space
        do_reset();
        @(negedge clk);
        check("wrap_req_valid", {31'b0, bus2.imem_req_valid}, 32'd1);
        check("wrap_first_addr", bus2.imem_req_addr, RST_B);
        bus2.imem_req_ready = 1'b1;
        @(negedge clk);
        bus2.imem_req_ready = 1'b0;
        bus2.imem_rsp_valid = 1'b1;
        bus2.imem_rsp_data  = 32'hCAFE_0001;
        @(negedge clk);
        bus2.imem_rsp_valid = 1'b0;
        check("wrap_id_valid", {31'b0, bus2.id_valid}, 32'd1);
        check("wrap_id_pc", bus2.id_pc, RST_B);
        check("wrap_id_pc_plus4", bus2.id_pc_plus4, 32'h0);
        check("wrap_id_instr", bus2.id_instr, 32'hCAFE_0001);
        bus2.id_ready = 1'b1;
        @(negedge clk);
        bus2.id_ready = 1'b0;
        check("wrap_second_valid", {31'b0, bus2.imem_req_valid}, 32'd1);
        check("wrap_second_addr", bus2.imem_req_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
